// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with multi-cycle EX sequencer and stall perf counter
module pipe_ctrl #(
    parameter int MC_W   = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              mc_start,
    input  logic [MC_W-1:0]   mc_cycles,
    input  logic              flush_req,
    input  logic [31:0]       flush_target,
    input  logic              perf_clr,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, BUSY} mc_state_e;

    mc_state_e         state_q, state_d;
    logic [MC_W-1:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [5:0]        stall_raw;
    logic              ex_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mc_start && mc_cycles == MC_W'(1)) begin
                    mc_done = 1'b1;
                end else if (mc_start && mc_cycles > MC_W'(1)) begin
                    cnt_d   = mc_cycles - MC_W'(1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - MC_W'(1);
                if (cnt_q == MC_W'(1)) begin
                    mc_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mc_busy = (state_q == BUSY);
    assign ex_req  = stallreq_ex | (mc_start & (mc_cycles != '0)) | mc_busy;

    always_comb begin
        stall_raw = 6'b000000;
        if (stallreq_mem)     stall_raw = 6'b011111;
        else if (ex_req)      stall_raw = 6'b001111;
        else if (stallreq_id) stall_raw = 6'b000111;
        else if (stallreq_if) stall_raw = 6'b000011;
    end

    // A flush only fires when EX can advance, so MEM/EX stall bits are already clear here.
    assign flush  = (flush_req | pend_q) & ~stall_raw[3];
    assign new_pc = flush_req ? flush_target : pend_pc_q;
    assign stall  = flush ? {stall_raw[5:3], 3'b000} : stall_raw;

    always_comb begin
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (flush) begin
            pend_d = 1'b0;
        end else if (flush_req) begin
            pend_d    = 1'b1;
            pend_pc_d = flush_target;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr)                        stall_cnt_d = '0;
        else if (stall[0] && ~&stall_cnt_q)  stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl driven by hand-computed directed vectors
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic        flush_req;
    logic [31:0] flush_target;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;
    logic [31:0] stall_cnt;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pipe_ctrl #(.MC_W(6), .PERF_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .flush_req    (flush_req),
        .flush_target (flush_target),
        .perf_clr     (perf_clr),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall", {26'd0, stall}, {26'd0, e.stall});
            chk("flush", {31'd0, flush}, {31'd0, e.flush});
            if (e.flush) chk("new_pc", new_pc, e.pc);
            chk("mc_busy", {31'd0, mc_busy}, {31'd0, e.busy});
            chk("mc_done", {31'd0, mc_done}, {31'd0, e.done});
            chk("stall_cnt", stall_cnt, e.cnt);
        end
    end

    // req = {mem, ex, id, if}
    task automatic step(input logic rn, input logic [3:0] req, input logic ms, input logic [5:0] mn,
                        input logic fr, input logic [31:0] ft, input logic pc,
                        input logic [5:0] es, input logic ef, input logic [31:0] ep,
                        input logic eb, input logic ed, input logic [31:0] ec);
        exp_t e;
        rst_n        = rn;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        mc_start     = ms;
        mc_cycles    = mn;
        flush_req    = fr;
        flush_target = ft;
        perf_clr     = pc;
        e.stall = es; e.flush = ef; e.pc = ep; e.busy = eb; e.done = ed; e.cnt = ec;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
        mc_start = 1'b0; mc_cycles = '0; flush_req = 1'b0; flush_target = '0; perf_clr = 1'b0;
        @(posedge clk);
        #1;
        // reset state
        step(0, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 0);
        step(0, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 0);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 0);
        // stall priority
        step(1, 4'b0010, 0, 0, 0, 0,      0, 6'h07, 0, 0,      0, 0, 0);
        step(1, 4'b1010, 0, 0, 0, 0,      0, 6'h1F, 0, 0,      0, 0, 1);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 2);
        step(1, 4'b0000, 0, 0, 0, 0,      1, 6'h00, 0, 0,      0, 0, 2);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 0);
        // N=4 op, restart ignored while busy, MEM stall does not freeze counter
        step(1, 4'b0000, 1, 4, 0, 0,      0, 6'h0F, 0, 0,      0, 0, 0);
        step(1, 4'b0000, 1, 2, 0, 0,      0, 6'h0F, 0, 0,      1, 0, 1);
        step(1, 4'b1000, 0, 0, 0, 0,      0, 6'h1F, 0, 0,      1, 0, 2);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h0F, 0, 0,      1, 1, 3);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 4);
        // N=1 and N=0
        step(1, 4'b0000, 1, 1, 0, 0,      0, 6'h0F, 0, 0,      0, 1, 4);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 5);
        step(1, 4'b0000, 1, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 5);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 5);
        // deferred flush behind MEM stall
        step(1, 4'b1000, 0, 0, 1, 32'h80, 0, 6'h1F, 0, 0,      0, 0, 5);
        step(1, 4'b1000, 0, 0, 0, 0,      0, 6'h1F, 0, 0,      0, 0, 6);
        step(1, 4'b1000, 0, 0, 0, 0,      0, 6'h1F, 0, 0,      0, 0, 7);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 1, 32'h80, 0, 0, 8);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 8);
        // newer deferred target overwrites older
        step(1, 4'b1000, 0, 0, 1, 32'h200,0, 6'h1F, 0, 0,      0, 0, 8);
        step(1, 4'b1000, 0, 0, 1, 32'h300,0, 6'h1F, 0, 0,      0, 0, 9);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 1, 32'h300,0, 0, 10);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 10);
        // flush overrides ID stall
        step(1, 4'b0010, 0, 0, 1, 32'h100,0, 6'h00, 1, 32'h100,0, 0, 10);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 10);
        // live request beats pending target
        step(1, 4'b1000, 0, 0, 1, 32'h500,0, 6'h1F, 0, 0,      0, 0, 10);
        step(1, 4'b0000, 0, 0, 1, 32'h600,0, 6'h00, 1, 32'h600,0, 0, 11);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 11);
        // reset mid-busy with pending flush
        step(1, 4'b0000, 1, 10, 0, 0,     0, 6'h0F, 0, 0,      0, 0, 11);
        step(1, 4'b0000, 0, 0, 1, 32'h400,0, 6'h0F, 0, 0,      1, 0, 12);
        step(0, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 0);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 0);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 0);
        // perf counter over IF stalls, then clear with concurrent stall
        for (int i = 0; i < 7; i++)
            step(1, 4'b0001, 0, 0, 0, 0,  0, 6'h03, 0, 0,      0, 0, i);
        step(1, 4'b0001, 0, 0, 0, 0,      1, 6'h03, 0, 0,      0, 0, 7);
        step(1, 4'b0000, 0, 0, 0, 0,      0, 6'h00, 0, 0,      0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d records unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
